// File: rtl/stream_mux_rr.sv
`default_nettype none
// +---------------------------------------------------------------------------+
// | stream_mux_rr : N-channel registered valid/ready stream multiplexer with  |
// |                 fixed-select or round-robin arbitration.                  |
// | Optional build macro STREAM_MUX_LOCK_EN enables round-robin packet lock.  |
// | Revision: 1.0                                                             |
// +---------------------------------------------------------------------------+
module stream_mux_rr #(
    parameter int N     = 4,
    parameter int WIDTH = 8,
    parameter int SELW  = $clog2(N)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 mode,
    input  logic [SELW-1:0]      sel,
    input  logic [N-1:0]         in_valid,
    input  logic [N*WIDTH-1:0]   in_data,
    input  logic [N-1:0]         in_last,
    output logic [N-1:0]         in_ready,
    output logic                 out_valid,
    output logic [WIDTH-1:0]     out_data,
    output logic [SELW-1:0]      out_chan,
    input  logic                 out_ready
);

    logic                out_valid_q, out_valid_d;
    logic [WIDTH-1:0]    out_data_q,  out_data_d;
    logic [SELW-1:0]     out_chan_q,  out_chan_d;
    logic [SELW-1:0]     last_q,      last_d;

`ifdef STREAM_MUX_LOCK_EN
    logic                lock_q,      lock_d;
    logic [SELW-1:0]     lock_chan_q, lock_chan_d;
`else
    logic                w_unused_last;
    assign w_unused_last = ^in_last;
`endif

    logic                w_load;
    logic                w_xfer;
    logic [N-1:0]        w_grant;
    logic [SELW-1:0]     w_gidx;
    logic [WIDTH-1:0]    w_gdata;
    logic [SELW-1:0]     w_idx;
    logic                w_found;

    assign w_load   = ~out_valid_q | out_ready;
    assign in_ready = w_grant & {N{w_load & ~rst}};
    assign w_xfer   = |(in_valid & in_ready);

    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        w_idx   = '0;
        if (!mode) begin
            if ((32'(sel) < N) && in_valid[sel]) begin
                w_grant[sel] = 1'b1;
            end
        end
`ifdef STREAM_MUX_LOCK_EN
        else if (lock_q) begin
            // Mid-packet: only the locked channel may be granted.
            if (in_valid[lock_chan_q]) begin
                w_grant[lock_chan_q] = 1'b1;
            end
        end
`endif
        else begin
            // Search starts one past the last served channel, wrapping at N.
            for (int k = 1; k <= N; k++) begin
                w_idx = SELW'((int'(last_q) + k) % N);
                if (!w_found && in_valid[w_idx]) begin
                    w_grant[w_idx] = 1'b1;
                    w_found        = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gidx  = '0;
        w_gdata = '0;
        for (int i = 0; i < N; i++) begin
            if (w_grant[i]) begin
                w_gidx  = SELW'(i);
                w_gdata = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_chan_d  = out_chan_q;
        last_d      = last_q;
        if (w_load) begin
            out_valid_d = w_xfer;
            if (w_xfer) begin
                out_data_d = w_gdata;
                out_chan_d = w_gidx;
            end
        end
        // Fixed-mode traffic leaves the round-robin history untouched.
        if (w_xfer && mode) begin
            last_d = w_gidx;
        end
    end

`ifdef STREAM_MUX_LOCK_EN
    always_comb begin
        lock_d      = lock_q;
        lock_chan_d = lock_chan_q;
        if (!mode) begin
            lock_d = 1'b0;
        end else if (w_xfer) begin
            lock_d      = ~in_last[w_gidx];
            lock_chan_d = w_gidx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q      <= 1'b0;
            lock_chan_q <= '0;
        end else begin
            lock_q      <= lock_d;
            lock_chan_q <= lock_chan_d;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_chan_q  <= '0;
            last_q      <= SELW'(N - 1);
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_chan_q  <= out_chan_d;
            last_q      <= last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_chan  = out_chan_q;

endmodule
`default_nettype wire
